mem_arb: RTL

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/tk_pkg.sv | 10 +
 rtl/mem_arb_timer.sv | 30 +++
 rtl/mem_arb.sv | 123 ++++++++++++
 3 files changed

// File: rtl/tk_pkg.sv
// tk_pkg: shared types for the miss arbiter.
package tk_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;
    typedef logic [2:0] trd_t;

    function automatic logic [7:0] trd_onehot(input trd_t t);
        return 8'b1 << t;
    endfunction
endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: counts BUSY cycles from start; expire flags the last allowed cycle.
module mem_arb_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic ack,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_q, run_d;

    always_comb begin
        expire = run_q && (cnt_q == CW'(TIMEOUT - 1));
        run_d  = start ? 1'b1 : (ack || expire) ? 1'b0 : run_q;
        cnt_d  = start ? '0 : run_q ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/mem_arb.sv
// mem_arb: round-robin I/D miss arbiter serialising one access at a time onto the
// backing-memory port, with a BUSY timeout that aborts a hung access.
module mem_arb
    import tk_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic [2:0]  i_trd,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_trd,
    output logic        i_gnt,
    output logic        d_gnt,
    output logic        i_done,
    output logic        d_done,
    output logic [31:0] rdata,
    output logic [2:0]  done_trd,
    output logic        err,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_ack,
    input  logic [31:0] m_rdata,
    output logic [7:0]  blocked_trd
);
    state_t      state_q, state_d;
    owner_t      own_q, own_d, last_q, last_d;
    trd_t        trd_q, trd_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic        we_q, we_d, err_q, err_d;
    logic [7:0]  blk_q, blk_d;
    logic        grant, sel_dside, ack_busy, expire;

    mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (grant),
        .ack    (ack_busy),
        .expire (expire)
    );

    always_comb begin
        ack_busy  = m_ack && (state_q == ST_BUSY);
        grant     = rst_n && (state_q == ST_IDLE) && (i_req || d_req);
        // On a tie the side that did not win last time goes first
        sel_dside = d_req && (!i_req || last_q == OWN_I);
        i_gnt     = grant && !sel_dside;
        d_gnt     = grant && sel_dside;
        state_d   = state_q;
        own_d     = own_q;
        last_d    = last_q;
        trd_d     = trd_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        blk_d     = blk_q;
        if (grant) begin
            state_d = ST_BUSY;
            own_d   = sel_dside ? OWN_D : OWN_I;
            last_d  = own_d;
            trd_d   = sel_dside ? d_trd : i_trd;
            addr_d  = sel_dside ? d_addr : i_addr;
            we_d    = sel_dside && d_we;
            wdata_d = sel_dside ? d_wdata : 32'd0;
            rdata_d = 32'd0;
            err_d   = 1'b0;
            blk_d   = blk_q | trd_onehot(trd_d);
        end else if (state_q == ST_BUSY && (ack_busy || expire)) begin
            state_d = ST_DONE;
            rdata_d = (ack_busy && !we_q) ? m_rdata : 32'd0;
            err_d   = !ack_busy;
        end else if (state_q == ST_DONE) begin
            state_d = ST_IDLE;
            blk_d   = blk_q & ~trd_onehot(trd_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            own_q   <= OWN_I;
            last_q  <= OWN_I;
            trd_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            last_q  <= last_d;
            trd_q   <= trd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            blk_q   <= blk_d;
        end
    end

    assign m_req       = (state_q == ST_BUSY);
    assign m_we        = we_q;
    assign m_addr      = addr_q;
    assign m_wdata     = wdata_q;
    assign i_done      = (state_q == ST_DONE) && (own_q == OWN_I);
    assign d_done      = (state_q == ST_DONE) && (own_q == OWN_D);
    assign err         = (state_q == ST_DONE) && err_q;
    assign rdata       = rdata_q;
    assign done_trd    = trd_q;
    assign blocked_trd = blk_q;
endmodule
